// File: rtl/serial_subtractor_nand_pkg.sv
// rtl/serial_subtractor_nand_pkg.sv - shared state encodings and helpers for the bit-serial NAND subtractor
package serial_subtractor_nand_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Bit counter must stay at least one bit wide even for WIDTH = 1.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    function automatic logic nand2(input logic p, input logic q);
        return ~(p & q);
    endfunction

endpackage

// File: rtl/serial_subtractor_nand_fs_nand.sv
// rtl/serial_subtractor_nand_fs_nand.sv - one-bit full subtractor built only from 2-input NANDs
module fs_nand
    import serial_subtractor_nand_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bo
);

    logic t1, u1, v1, p;
    logic t2, u2, v2;
    logic nx, np, g1, g2;

    // p = x ^ y, then d = p ^ bin, each through the 4-NAND XOR.
    assign t1 = nand2(x, y);
    assign u1 = nand2(x, t1);
    assign v1 = nand2(y, t1);
    assign p  = nand2(u1, v1);

    assign t2 = nand2(p, bin);
    assign u2 = nand2(p, t2);
    assign v2 = nand2(bin, t2);
    assign d  = nand2(u2, v2);

    // bo = (~x & y) | (~p & bin) as a NAND-NAND sum of products.
    assign nx = nand2(x, x);
    assign np = nand2(p, p);
    assign g1 = nand2(nx, y);
    assign g2 = nand2(np, bin);
    assign bo = nand2(g1, g2);

endmodule

// File: rtl/serial_subtractor_nand.sv
// rtl/serial_subtractor_nand.sv - bit-serial unsigned subtractor, LSB first, one NAND cell plus registered borrow
module serial_subtractor_nand
    import serial_subtractor_nand_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             bout_q, bout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             fs_d, fs_bo;
    logic [WIDTH-1:0] acc_shift;

    fs_nand u_fs (
        .x   (a_sh_q[0]),
        .y   (b_sh_q[0]),
        .bin (borrow_q),
        .d   (fs_d),
        .bo  (fs_bo)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        acc_d     = acc_q;
        diff_d    = diff_q;
        borrow_d  = borrow_q;
        bout_d    = bout_q;
        // Result bits enter at the MSB so bit 0 lands in acc[0] after WIDTH shifts.
        acc_shift            = acc_q >> 1;
        acc_shift[WIDTH-1]   = fs_d;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_SHIFT;
                    a_sh_d   = a;
                    b_sh_d   = b;
                    borrow_d = 1'b0;
                    acc_d    = '0;
                    diff_d   = '0;
                    cnt_d    = '0;
                end
            end
            ST_SHIFT: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                borrow_d = fs_bo;
                acc_d    = acc_shift;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = ST_DONE;
                    diff_d  = acc_shift;
                    bout_d  = fs_bo;
                    cnt_d   = '0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_SHIFT);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            acc_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            acc_q    <= acc_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor_nand.sv
// tb/tb_serial_subtractor_nand.sv - scoreboard bench for serial_subtractor_nand at WIDTH 8 and 4
module tb_serial_subtractor_nand;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, bout8;
    logic [7:0] diff8;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4, bout4;
    logic [3:0] diff4;

    int checks   = 0;
    int failures = 0;

    logic [8:0] q8[$];
    logic [4:0] q4[$];

    always #5 clk = ~clk;

    serial_subtractor_nand #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
    );

    serial_subtractor_nand #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] model8(input logic [7:0] x, input logic [7:0] y);
        logic [8:0] r;
        r = {1'b0, x} - {1'b0, y};
        return {r[8], r[7:0]};
    endfunction

    // Issues one WIDTH=8 operation, checks latency, strobe width, result and hold.
    task automatic do_op8(input logic [7:0] x, input logic [7:0] y, input string name);
        logic [8:0] exp;
        int n;
        a8 = x; b8 = y; start8 = 1'b1;
        q8.push_back(model8(x, y));
        tick();
        start8 = 1'b0;
        a8 = $urandom; b8 = $urandom;
        n = 0;
        while (!done8 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 8) begin
            failures++;
            $display("FAIL %s_latency got=%0d exp=8", name, n);
        end
        exp = q8.pop_front();
        checks++;
        if ({bout8, diff8} !== exp) begin
            failures++;
            $display("FAIL %s_result got diff=%h bout=%b exp diff=%h bout=%b", name, diff8, bout8, exp[7:0], exp[8]);
        end
        tick();
        tick();
        checks++;
        if (done8 !== 1'b0 || busy8 !== 1'b0 || {bout8, diff8} !== exp) begin
            failures++;
            $display("FAIL %s_hold got done=%b busy=%b diff=%h bout=%b exp done=0 busy=0 diff=%h bout=%b",
                     name, done8, busy8, diff8, bout8, exp[7:0], exp[8]);
        end
    endtask

    task automatic test_reset();
        int dones;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start8 = 1'($urandom); a8 = $urandom; b8 = $urandom;
            start4 = 1'($urandom); a4 = $urandom; b4 = $urandom;
            tick();
        end
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || diff8 !== 8'h00 || bout8 !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got busy=%b done=%b diff=%h bout=%b exp 0 0 00 0", busy8, done8, diff8, bout8);
        end
        checks++;
        if (busy4 !== 1'b0 || done4 !== 1'b0 || diff4 !== 4'h0 || bout4 !== 1'b0) begin
            failures++;
            $display("FAIL reset_state4 got busy=%b done=%b diff=%h bout=%b exp 0 0 0 0", busy4, done4, diff4, bout4);
        end
        start8 = 1'b0; start4 = 1'b0;
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done8 || done4 || busy8) dones++;
        end
        checks++;
        if (dones !== 0) begin
            failures++;
            $display("FAIL reset_idle got activity=%0d exp=0", dones);
        end
    endtask

    task automatic test_basic();
        do_op8(8'd100, 8'd37, "basic");
        checks++;
        if (diff8 !== 8'h3F || bout8 !== 1'b0) begin
            failures++;
            $display("FAIL basic_const got diff=%h bout=%b exp diff=3f bout=0", diff8, bout8);
        end
    endtask

    task automatic test_wrap();
        do_op8(8'h00, 8'h01, "wrap_under");
        checks++;
        if (diff8 !== 8'hFF || bout8 !== 1'b1) begin
            failures++;
            $display("FAIL wrap_under_const got diff=%h bout=%b exp diff=ff bout=1", diff8, bout8);
        end
        do_op8(8'hA5, 8'hA5, "wrap_equal");
        checks++;
        if (diff8 !== 8'h00 || bout8 !== 1'b0) begin
            failures++;
            $display("FAIL wrap_equal_const got diff=%h bout=%b exp diff=00 bout=0", diff8, bout8);
        end
    endtask

    task automatic test_busy();
        logic [8:0] exp;
        int dones;
        a8 = 8'h80; b8 = 8'h01; start8 = 1'b1;
        q8.push_back(model8(8'h80, 8'h01));
        tick();
        start8 = 1'b0;
        dones = 0;
        for (int i = 1; i <= 24; i++) begin
            if (i == 3) begin
                a8 = 8'h10; b8 = 8'h20; start8 = 1'b1;
            end
            tick();
            start8 = 1'b0;
            if (done8) begin
                dones++;
                checks++;
                if (q8.size() == 0) begin
                    failures++;
                    $display("FAIL busy_extra_done got diff=%h bout=%b exp no done", diff8, bout8);
                end else begin
                    exp = q8.pop_front();
                    if ({bout8, diff8} !== exp || diff8 !== 8'h7F) begin
                        failures++;
                        $display("FAIL busy_result got diff=%h bout=%b exp diff=%h bout=%b",
                                 diff8, bout8, exp[7:0], exp[8]);
                    end
                end
            end
        end
        checks++;
        if (dones !== 1) begin
            failures++;
            $display("FAIL busy_done_count got=%0d exp=1", dones);
        end
        q8.delete();
    endtask

    task automatic test_reset_mid();
        int dones;
        a8 = 8'hF0; b8 = 8'h0F; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || diff8 !== 8'h00 || bout8 !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_state got busy=%b done=%b diff=%h bout=%b exp 0 0 00 0", busy8, done8, diff8, bout8);
        end
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done8) dones++;
        end
        checks++;
        if (dones !== 0) begin
            failures++;
            $display("FAIL reset_mid_done got=%0d exp=0", dones);
        end
        do_op8(8'h05, 8'h07, "after_reset");
        checks++;
        if (diff8 !== 8'hFE || bout8 !== 1'b1) begin
            failures++;
            $display("FAIL after_reset_const got diff=%h bout=%b exp diff=fe bout=1", diff8, bout8);
        end
    endtask

    task automatic test_back_to_back();
        int dones;
        int budget;
        logic [4:0] exp;
        logic [4:0] r;
        dones = 0;
        fork
            begin
                for (int x = 0; x < 16; x++) begin
                    for (int y = 0; y < 16; y++) begin
                        a4 = 4'(x); b4 = 4'(y); start4 = 1'b1;
                        r = {1'b0, 4'(x)} - {1'b0, 4'(y)};
                        q4.push_back(r);
                        tick();
                        start4 = 1'b0;
                        a4 = $urandom; b4 = $urandom;
                        for (int k = 0; k < 5; k++) tick();
                    end
                end
            end
            begin
                budget = 0;
                while (dones < 256 && budget < 256 * 6 + 50) begin
                    tick();
                    budget++;
                    if (done4) begin
                        dones++;
                        checks++;
                        if (q4.size() == 0) begin
                            failures++;
                            $display("FAIL b2b_extra_done got diff=%h bout=%b", diff4, bout4);
                        end else begin
                            exp = q4.pop_front();
                            if ({bout4, diff4} !== exp) begin
                                failures++;
                                $display("FAIL b2b_result got diff=%h bout=%b exp diff=%h bout=%b",
                                         diff4, bout4, exp[3:0], exp[4]);
                            end
                        end
                    end
                end
            end
        join
        checks++;
        if (dones !== 256 || q4.size() !== 0) begin
            failures++;
            $display("FAIL b2b_done_count got=%0d pending=%0d exp=256 pending=0", dones, q4.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_busy();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
